// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one keccak_core between NUM_REQ stream clients; a grant spans a whole transaction.
// Optional KECCAK_ARB_PRIO0_EN: requester 0 wins every IDLE decision, the rest stay round-robin.
module keccak_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = 32,
    parameter int OUT_DWIDTH = 256,
    parameter int MODE_W     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*MODE_W-1:0]      req_mode_i,
    input  logic [NUM_REQ-1:0]             req_stop_i,
    input  logic [NUM_REQ*DWIDTH-1:0]      req_tdata_i,
    input  logic [NUM_REQ-1:0]             req_tvalid_i,
    input  logic [NUM_REQ-1:0]             req_tlast_i,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]  req_tkeep_i,
    output logic [NUM_REQ-1:0]             req_tready_o,
    output logic [OUT_DWIDTH-1:0]          rsp_tdata_o,
    output logic [KEEP_WIDTH-1:0]          rsp_tkeep_o,
    output logic [NUM_REQ-1:0]             rsp_tvalid_o,
    output logic [NUM_REQ-1:0]             rsp_tlast_o,
    input  logic [NUM_REQ-1:0]             rsp_tready_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic                           busy_o,
    output logic                           core_start_o,
    output logic                           core_stop_o,
    output logic [MODE_W-1:0]              core_mode_o,
    output logic [DWIDTH-1:0]              core_tdata_o,
    output logic                           core_tvalid_o,
    output logic                           core_tlast_o,
    output logic [KEEP_WIDTH-1:0]          core_tkeep_o,
    input  logic                           core_tready_i,
    input  logic [OUT_DWIDTH-1:0]          core_tdata_i,
    input  logic                           core_tvalid_i,
    input  logic                           core_tlast_i,
    input  logic [KEEP_WIDTH-1:0]          core_tkeep_i,
    output logic                           core_tready_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
`ifdef KECCAK_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, START, ACTIVE, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [IDX_W-1:0]    gnt_idx_reg, gnt_idx_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [MODE_W-1:0]   mode_reg, mode_next;
    logic                out_seen_reg, out_seen_next;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                active;
    logic                src_hs;

    logic [MODE_W-1:0]     mode_arr  [NUM_REQ];
    logic [DWIDTH-1:0]     tdata_arr [NUM_REQ];
    logic [KEEP_WIDTH-1:0] tkeep_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign mode_arr[gi]  = req_mode_i[gi*MODE_W +: MODE_W];
            assign tdata_arr[gi] = req_tdata_i[gi*DWIDTH +: DWIDTH];
            assign tkeep_arr[gi] = req_tkeep_i[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(rr_ptr_reg) + off) % NUM_REQ;
            if (req_i[IDX_W'(idx)] && !(PRIO0 && idx == 0)) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
        if (PRIO0 && req_i[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
    end

    assign active = (state_reg == ACTIVE);
    assign src_hs = active && core_tvalid_i && rsp_tready_i[gnt_idx_reg];

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        mode_next     = mode_reg;
        out_seen_next = out_seen_reg;
        core_start_o  = 1'b0;
        core_stop_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    gnt_idx_next       = pick_idx;
                    mode_next          = mode_arr[pick_idx];
                    out_seen_next      = 1'b0;
                    state_next         = START;
                end
            end
            START: begin
                core_start_o = 1'b1;
                state_next   = ACTIVE;
            end
            ACTIVE: begin
                if (src_hs)
                    out_seen_next = 1'b1;
                // A final beat takes precedence over a concurrent stop request.
                if (src_hs && core_tlast_i) begin
                    gnt_next   = '0;
                    state_next = RELEASE;
                end else if (req_stop_i[gnt_idx_reg] && out_seen_reg) begin
                    core_stop_o = 1'b1;
                    gnt_next    = '0;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (int'(gnt_idx_reg) == NUM_REQ - 1)
                    rr_ptr_next = PRIO0 ? IDX_W'(1) : '0;
                else
                    rr_ptr_next = gnt_idx_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            rr_ptr_reg   <= '0;
            mode_reg     <= '0;
            out_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            mode_reg     <= mode_next;
            out_seen_reg <= out_seen_next;
        end
    end

    assign gnt_o       = gnt_reg;
    assign busy_o      = (state_reg != IDLE);
    assign core_mode_o = mode_reg;

    // Stream muxing is gated by ACTIVE so stray beats never reach the core or other clients.
    always_comb begin
        req_tready_o  = '0;
        rsp_tvalid_o  = '0;
        rsp_tlast_o   = '0;
        rsp_tdata_o   = '0;
        rsp_tkeep_o   = '0;
        core_tvalid_o = 1'b0;
        core_tlast_o  = 1'b0;
        core_tdata_o  = '0;
        core_tkeep_o  = '0;
        core_tready_o = 1'b0;
        if (active) begin
            core_tvalid_o              = req_tvalid_i[gnt_idx_reg];
            core_tlast_o               = req_tlast_i[gnt_idx_reg];
            core_tdata_o               = tdata_arr[gnt_idx_reg];
            core_tkeep_o               = tkeep_arr[gnt_idx_reg];
            req_tready_o[gnt_idx_reg]  = core_tready_i;
            rsp_tvalid_o[gnt_idx_reg]  = core_tvalid_i;
            rsp_tlast_o[gnt_idx_reg]   = core_tlast_i;
            core_tready_o              = rsp_tready_i[gnt_idx_reg];
            rsp_tdata_o                = core_tdata_i;
            rsp_tkeep_o                = core_tkeep_i;
        end
    end
endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: the core side is driven directly by the bench.
module tb_keccak_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DWIDTH     = 256;
    localparam int KEEP_WIDTH = 32;
    localparam int OUT_DWIDTH = 256;
    localparam int MODE_W     = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*MODE_W-1:0]     req_mode_i;
    logic [NUM_REQ-1:0]            req_stop_i;
    logic [NUM_REQ*DWIDTH-1:0]     req_tdata_i;
    logic [NUM_REQ-1:0]            req_tvalid_i;
    logic [NUM_REQ-1:0]            req_tlast_i;
    logic [NUM_REQ*KEEP_WIDTH-1:0] req_tkeep_i;
    logic [NUM_REQ-1:0]            req_tready_o;
    logic [OUT_DWIDTH-1:0]         rsp_tdata_o;
    logic [KEEP_WIDTH-1:0]         rsp_tkeep_o;
    logic [NUM_REQ-1:0]            rsp_tvalid_o;
    logic [NUM_REQ-1:0]            rsp_tlast_o;
    logic [NUM_REQ-1:0]            rsp_tready_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic                          busy_o;
    logic                          core_start_o;
    logic                          core_stop_o;
    logic [MODE_W-1:0]             core_mode_o;
    logic [DWIDTH-1:0]             core_tdata_o;
    logic                          core_tvalid_o;
    logic                          core_tlast_o;
    logic [KEEP_WIDTH-1:0]         core_tkeep_o;
    logic                          core_tready_i;
    logic [OUT_DWIDTH-1:0]         core_tdata_i;
    logic                          core_tvalid_i;
    logic                          core_tlast_i;
    logic [KEEP_WIDTH-1:0]         core_tkeep_i;
    logic                          core_tready_o;

    always #5 clk = ~clk;

    keccak_arbiter #(
        .NUM_REQ(NUM_REQ), .DWIDTH(DWIDTH), .KEEP_WIDTH(KEEP_WIDTH),
        .OUT_DWIDTH(OUT_DWIDTH), .MODE_W(MODE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .req_mode_i(req_mode_i), .req_stop_i(req_stop_i),
        .req_tdata_i(req_tdata_i), .req_tvalid_i(req_tvalid_i),
        .req_tlast_i(req_tlast_i), .req_tkeep_i(req_tkeep_i),
        .req_tready_o(req_tready_o),
        .rsp_tdata_o(rsp_tdata_o), .rsp_tkeep_o(rsp_tkeep_o),
        .rsp_tvalid_o(rsp_tvalid_o), .rsp_tlast_o(rsp_tlast_o),
        .rsp_tready_i(rsp_tready_i),
        .gnt_o(gnt_o), .busy_o(busy_o),
        .core_start_o(core_start_o), .core_stop_o(core_stop_o), .core_mode_o(core_mode_o),
        .core_tdata_o(core_tdata_o), .core_tvalid_o(core_tvalid_o),
        .core_tlast_o(core_tlast_o), .core_tkeep_o(core_tkeep_o),
        .core_tready_i(core_tready_i),
        .core_tdata_i(core_tdata_i), .core_tvalid_i(core_tvalid_i),
        .core_tlast_i(core_tlast_i), .core_tkeep_i(core_tkeep_i),
        .core_tready_o(core_tready_o)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [OUT_DWIDTH-1:0] rx_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst && core_start_o) start_cnt++;
        if (!rst && rsp_tvalid_o[2] && rsp_tready_i[2]) rx_q.push_back(rsp_tdata_o);
    end

    typedef struct {
        logic [3:0] sv;
        logic [3:0] sl;
        logic       ctr;
        logic       cv;
        logic [3:0] rr;
        logic       e_ctv;
        logic       e_ctl;
        logic [3:0] e_rqr;
        logic       e_cto;
        logic [3:0] e_rsv;
    } vec_t;

    vec_t tbl[5];
    logic [DWIDTH-1:0] dat[NUM_REQ];
    logic [KEEP_WIDTH-1:0] kp[NUM_REQ];
    logic [OUT_DWIDTH-1:0] beats[3];
    logic [MODE_W-1:0] modes[NUM_REQ];

    // One fixed-length job: START, one tlast beat in ACTIVE, RELEASE, IDLE.
    task automatic fixed_txn(input int g);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << g;
        cyc(); #1;
        chk($sformatf("rr_gnt_%0d", g), gnt_o, one_hot);
        chk("rr_start", core_start_o, 1'b1);
        chk("rr_mode", core_mode_o, modes[g]);
        cyc();
        core_tvalid_i = 1'b1; core_tlast_i = 1'b1; rsp_tready_i = 4'b1111; #1;
        chk("rr_rsp_tvalid", rsp_tvalid_o, one_hot);
        cyc();
        core_tvalid_i = 1'b0; core_tlast_i = 1'b0; rsp_tready_i = 4'b0000; #1;
        chk("rr_release_gnt", gnt_o, 4'b0000);
        chk("rr_release_busy", busy_o, 1'b1);
        cyc(); #1;
        chk("rr_idle_busy", busy_o, 1'b0);
        chk("rr_idle_start", core_start_o, 1'b0);
    endtask

    initial begin
        //         sv       sl       ctr   cv    rr       ctv   ctl   rqr      cto   rsv
        tbl[0] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0000};
        tbl[1] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[2] = '{4'b1010, 4'b1000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010};
        tbl[3] = '{4'b0101, 4'b0101, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010};
        tbl[4] = '{4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010};
        for (int i = 0; i < NUM_REQ; i++) begin
            dat[i] = {8{32'hA5A50000 + 32'(i * 17)}};
            kp[i]  = 32'hFFFF0000 | 32'(i + 1);
        end
        beats[0] = {8{32'h11111111}};
        beats[1] = {8{32'h22222222}};
        beats[2] = {8{32'h33333333}};
        modes[0] = 3'd2; modes[1] = 3'd1; modes[2] = 3'd4; modes[3] = 3'd3;

        rst = 1'b1;
        req_i = '0; req_stop_i = '0; req_tvalid_i = '0; req_tlast_i = '0;
        req_mode_i = {modes[3], modes[2], modes[1], modes[0]};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tdata_i[i*DWIDTH +: DWIDTH] = dat[i];
            req_tkeep_i[i*KEEP_WIDTH +: KEEP_WIDTH] = kp[i];
        end
        rsp_tready_i = '0; core_tready_i = 1'b0; core_tdata_i = '0;
        core_tvalid_i = 1'b0; core_tlast_i = 1'b0; core_tkeep_i = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", core_start_o, 1'b0);
        chk("rst_mode", core_mode_o, 3'd0);
        chk("rst_req_tready", req_tready_o, 4'b0000);

        // Single requester 1, one absorb beat, one digest beat
        cyc(); rst = 1'b0; req_i = 4'b0010; #1;
        chk("t1_idle_gnt", gnt_o, 4'b0000);
        cyc(); #1;
        chk("t1_gnt", gnt_o, 4'b0010);
        chk("t1_start", core_start_o, 1'b1);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_mode", core_mode_o, modes[1]);
        cyc(); req_i = 4'b0000; #1;
        chk("t1_start_off", core_start_o, 1'b0);
        chk("t1_gnt_kept", gnt_o, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            req_tvalid_i = tbl[i].sv; req_tlast_i = tbl[i].sl;
            core_tready_i = tbl[i].ctr; core_tvalid_i = tbl[i].cv; rsp_tready_i = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_core_tvalid", i), core_tvalid_o, tbl[i].e_ctv);
            chk($sformatf("v%0d_core_tlast", i), core_tlast_o, tbl[i].e_ctl);
            chk($sformatf("v%0d_req_tready", i), req_tready_o, tbl[i].e_rqr);
            chk($sformatf("v%0d_core_tready", i), core_tready_o, tbl[i].e_cto);
            chk($sformatf("v%0d_rsp_tvalid", i), rsp_tvalid_o, tbl[i].e_rsv);
            chk($sformatf("v%0d_core_tdata", i), core_tdata_o, dat[1]);
            chk($sformatf("v%0d_core_tkeep", i), core_tkeep_o, kp[1]);
        end
        cyc();
        req_tvalid_i = '0; req_tlast_i = '0; core_tready_i = 1'b0;
        core_tvalid_i = 1'b1; core_tlast_i = 1'b1; core_tdata_i = {8{32'hDEADBEEF}};
        core_tkeep_i = '1; rsp_tready_i = 4'b0010; #1;
        chk("t1_rsp_tvalid", rsp_tvalid_o, 4'b0010);
        chk("t1_rsp_tlast", rsp_tlast_o, 4'b0010);
        chk("t1_digest", rsp_tdata_o, {8{32'hDEADBEEF}});
        chk("t1_rsp_tkeep", rsp_tkeep_o, 32'hFFFFFFFF);
        chk("t1_core_tready", core_tready_o, 1'b1);
        cyc();
        core_tvalid_i = 1'b0; core_tlast_i = 1'b0; rsp_tready_i = '0; #1;
        chk("t1_release_gnt", gnt_o, 4'b0000);
        chk("t1_release_busy", busy_o, 1'b1);
        chk("t1_release_rsp", rsp_tvalid_o, 4'b0000);
        cyc(); #1;
        chk("t1_idle_busy", busy_o, 1'b0);
        chk("t1_start_pulses", start_cnt, 1);

        // All four requesting from reset: 0,1,2,3,0
        cyc(); rst = 1'b1; req_i = 4'b1111;
        cyc(); rst = 1'b0;
        fixed_txn(0); fixed_txn(1); fixed_txn(2); fixed_txn(3); fixed_txn(0);
        req_i = 4'b0000;

        // XOF on requester 2: early stop ignored, back-pressure, then stop
        cyc(); req_i = 4'b0100; rx_q.delete(); #1;
        chk("x_idle_busy", busy_o, 1'b0);
        cyc(); #1;
        chk("x_gnt", gnt_o, 4'b0100);
        chk("x_mode", core_mode_o, modes[2]);
        cyc(); req_stop_i = 4'b0100; #1;
        chk("x_early_stop", core_stop_o, 1'b0);
        cyc(); #1;
        chk("x_early_stop2", core_stop_o, 1'b0);
        chk("x_gnt_kept", gnt_o, 4'b0100);
        cyc(); req_stop_i = '0; core_tvalid_i = 1'b1; core_tdata_i = beats[0]; rsp_tready_i = 4'b0100; #1;
        chk("x_beat0_valid", rsp_tvalid_o, 4'b0100);
        cyc(); core_tdata_i = beats[1];
        cyc(); core_tdata_i = beats[2]; rsp_tready_i = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            #1;
            chk($sformatf("x_stall%0d_core_tready", k), core_tready_o, 1'b0);
            chk($sformatf("x_stall%0d_data", k), rsp_tdata_o, beats[2]);
            chk($sformatf("x_stall%0d_valid", k), rsp_tvalid_o, 4'b0100);
        end
        cyc(); rsp_tready_i = 4'b0100; #1;
        chk("x_resume_tready", core_tready_o, 1'b1);
        cyc(); core_tvalid_i = 1'b0; rsp_tready_i = '0; req_stop_i = 4'b0100; #1;
        chk("x_stop", core_stop_o, 1'b1);
        chk("x_beats", rx_q.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("x_beat%0d", k), (k < rx_q.size()) ? rx_q[k] : '0, beats[k]);
        cyc(); req_stop_i = '0; req_i = '0; #1;
        chk("x_stop_once", core_stop_o, 1'b0);
        chk("x_release_gnt", gnt_o, 4'b0000);
        chk("x_release_busy", busy_o, 1'b1);

        // Stop coinciding with the tlast handshake ends as a fixed-length job
        cyc(); req_i = 4'b0100; #1;
        chk("s_idle_busy", busy_o, 1'b0);
        cyc();
        cyc(); core_tvalid_i = 1'b1; rsp_tready_i = 4'b0100;
        cyc(); core_tlast_i = 1'b1; req_stop_i = 4'b0100; #1;
        chk("s_no_stop", core_stop_o, 1'b0);
        chk("s_rsp_tlast", rsp_tlast_o, 4'b0100);
        cyc(); core_tvalid_i = 1'b0; core_tlast_i = 1'b0; req_stop_i = '0; req_i = '0; rsp_tready_i = '0; #1;
        chk("s_release_gnt", gnt_o, 4'b0000);
        chk("s_release_stop", core_stop_o, 1'b0);

        // Pointer now at 3: req 1001 picks 3, or 0 under fixed priority
        cyc(); req_i = 4'b1001; #1;
        chk("p_idle_busy", busy_o, 1'b0);
        cyc(); #1;
`ifdef KECCAK_ARB_PRIO0_EN
        chk("p_gnt", gnt_o, 4'b0001);
`else
        chk("p_gnt", gnt_o, 4'b1000);
`endif
        // Reset while ACTIVE with live traffic on every input
        cyc();
        req_tvalid_i = 4'b1111; core_tready_i = 1'b1; core_tvalid_i = 1'b1;
        core_tdata_i = beats[1]; rsp_tready_i = 4'b1111; rst = 1'b1; #1;
        chk("r_active_core_tvalid", core_tvalid_o, 1'b1);
        cyc(); rst = 1'b0; req_i = '0; #1;
        chk("r_gnt", gnt_o, 4'b0000);
        chk("r_busy", busy_o, 1'b0);
        chk("r_core_tvalid", core_tvalid_o, 1'b0);
        chk("r_core_tready", core_tready_o, 1'b0);
        chk("r_req_tready", req_tready_o, 4'b0000);
        chk("r_rsp_tvalid", rsp_tvalid_o, 4'b0000);
        chk("r_rsp_tdata", rsp_tdata_o, 256'd0);
        chk("r_mode", core_mode_o, 3'd0);
        chk("r_start", core_start_o, 1'b0);
        cyc(); req_tvalid_i = '0; core_tvalid_i = 1'b0; #1;
        chk("r_idle_busy", busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
